// File: rtl/score_packer.sv
// Requantises signed class scores to offset-binary bytes and packs one frame
// of NUM_CLASS bytes into a wide output word, flagging short and long frames.
//
// state   | meaning
// COLLECT | storing beats into byte slot cnt until the final class arrives
// DRAIN   | discarding the tail of an over-long frame until s_last
module score_packer #(
  parameter int NUM_CLASS = 43,
  parameter int ACC_W     = 32,
  parameter int BYTE_W    = 8,
  parameter int SHIFT     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [ACC_W-1:0]            s_data,
  input  logic                        s_last,
  output logic                        o_valid,
  output logic [NUM_CLASS*BYTE_W-1:0] o_data,
  output logic                        o_err,
  output logic [15:0]                 o_frames
);

  localparam int CNT_W   = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int XW      = ACC_W + 1;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [CNT_W-1:0]     LAST_SLOT = CNT_W'(NUM_CLASS - 1);
  localparam logic signed [XW-1:0] RND       = (SHIFT > 0) ? (XW'(1) << RND_POS) : '0;
  localparam logic signed [XW-1:0] SAT_HI    = XW'(127);
  localparam logic signed [XW-1:0] SAT_LO    = XW'(-128);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]                   cnt, cnt_nxt;
  logic [NUM_CLASS-1:0][BYTE_W-1:0]   coll;
  logic [NUM_CLASS-1:0][BYTE_W-1:0]   frame_bytes;

  logic                 accept;
  logic                 wr_en;
  logic                 good;
  logic                 err;
  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] sum;
  logic signed [XW-1:0] shr;
  logic [7:0]           byte_q;

  assign s_ready = rst_n;
  assign accept  = s_valid && s_ready;

  // One extra bit of headroom so the rounding add can never overflow.
  always_comb begin
    ext = {s_data[ACC_W-1], s_data};
    sum = ext + RND;
    shr = sum >>> SHIFT;
    if (shr > SAT_HI) begin
      byte_q = 8'hFF;
    end else if (shr < SAT_LO) begin
      byte_q = 8'h00;
    end else begin
      byte_q = {~shr[7], shr[6:0]};
    end
  end

  // The final class goes straight from the live beat into the output word.
  always_comb begin
    frame_bytes                = coll;
    frame_bytes[NUM_CLASS-1]   = byte_q;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    good      = 1'b0;
    err       = 1'b0;
    if (accept) begin
      case (state)
        COLLECT: begin
          if (cnt == LAST_SLOT && s_last) begin
            good    = 1'b1;
            cnt_nxt = '0;
          end else if (s_last) begin
            err     = 1'b1;
            cnt_nxt = '0;
          end else if (cnt == LAST_SLOT) begin
            err       = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (s_last) begin
            state_nxt = COLLECT;
          end
        end
        default: begin
          state_nxt = COLLECT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      cnt      <= '0;
      coll     <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_data   <= '0;
      o_frames <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      o_valid <= good;
      o_err   <= err;
      if (wr_en) begin
        coll[cnt] <= byte_q;
      end
      if (good) begin
        o_data   <= frame_bytes;
        o_frames <= o_frames + 16'd1;
      end
    end
  end

endmodule

// File: doc/score_packer.md
SCORE_PACKER -- requirements
Module: score_packer

Interface
REQ-001 The module SHALL have parameter NUM_CLASS, default 43, giving the number of class scores per frame.
REQ-002 The module SHALL have parameter ACC_W, default 32, giving the signed accumulator width of input scores.
REQ-003 The module SHALL have parameter BYTE_W, fixed at 8, giving the packed byte width.
REQ-004 The module SHALL have parameter SHIFT, default 8, range 0..ACC_W-1, giving the requantisation right-shift.
REQ-005 The module SHALL have port clk, input, 1 bit: clock, all state on the rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port s_valid, input, 1 bit: input score beat valid.
REQ-008 The module SHALL have port s_ready, output, 1 bit: beat accepted when s_valid && s_ready.
REQ-009 The module SHALL have port s_data, input, ACC_W bits: signed two's-complement class score.
REQ-010 The module SHALL have port s_last, input, 1 bit: marks the final beat of a frame.
REQ-011 The module SHALL have port o_valid, output, 1 bit: one-cycle pulse marking a packed frame.
REQ-012 The module SHALL have port o_data, output, NUM_CLASS*8 bits: packed bytes, class k in bits [8k+7:8k].
REQ-013 The module SHALL have port o_err, output, 1 bit: one-cycle pulse on a frame-length error.
REQ-014 The module SHALL have port o_frames, output, 16 bits: count of good frames, wrapping modulo 2^16.

Function
REQ-015 Requantisation SHALL compute r = (s_data + 2^(SHIFT-1)) >>> SHIFT in ACC_W+1 bits with no overflow; SHIFT=0 SHALL give r = s_data.
REQ-016 r SHALL saturate to [-128,127]; the byte SHALL be the saturated value with the MSB inverted (offset binary), so unsigned byte order equals signed score order.
REQ-017 A beat counter cnt (0..NUM_CLASS-1) SHALL select the byte slot written by each accepted beat in COLLECT.
REQ-018 The FSM SHALL have states COLLECT and DRAIN; reset state is COLLECT.
REQ-019 In COLLECT, an accepted beat with cnt==NUM_CLASS-1 and s_last=1 (good frame) SHALL load all NUM_CLASS bytes into o_data, pulse o_valid, increment o_frames, and reset cnt to 0.
REQ-020 These updates SHALL appear exactly one cycle after the accepting edge.
REQ-021 In COLLECT, an accepted beat with s_last=1 and cnt<NUM_CLASS-1 (short frame) SHALL pulse o_err one cycle later, discard the partial frame, reset cnt to 0 and remain in COLLECT.
REQ-022 In COLLECT, an accepted beat with cnt==NUM_CLASS-1 and s_last=0 (long frame) SHALL pulse o_err one cycle later, discard the frame, reset cnt to 0 and enter DRAIN.
REQ-023 In DRAIN, accepted beats SHALL be discarded; the beat carrying s_last=1 SHALL return the FSM to COLLECT with no further o_err.
REQ-024 o_data SHALL change only on a good frame and SHALL otherwise hold its last value, including across errors and while the next frame is collected.
REQ-025 s_ready SHALL be 1 in every state whenever rst_n is high, so back-to-back frames with no idle cycles between them are accepted.
REQ-026 Cycles with s_valid=0 SHALL leave all state unchanged.
REQ-027 When NUM_CLASS==1, every accepted beat with s_last=1 SHALL be a good frame.

Reset
REQ-028 While rst_n=0, the module SHALL hold s_ready=0, o_valid=0, o_err=0, o_data=0, o_frames=0, cnt=0 and state=COLLECT.
REQ-029 An assertion of rst_n mid-frame SHALL discard the partial frame, and the first beat after release SHALL be class 0.

Verification (NUM_CLASS=4, SHIFT=8, ACC_W=32)
REQ-030 Frame of s_data 0, 0x180, 0xFFFFFFFF, 0x7FFFFFFF with s_last on beat 4 -> one cycle after beat 4: o_valid=1, o_data=0xFF808280, o_frames=1.
REQ-031 Frame with s_data=0x80000000 in class 2 and 0 elsewhere -> o_data byte 2 = 0x00 and all other bytes = 0x80.
REQ-032 s_last on beat 2 -> o_err pulses once, o_valid stays 0, o_data and o_frames unchanged; the next 4-beat frame packs correctly.
REQ-033 Six-beat frame with s_last on beat 6 -> o_err pulses once after beat 4, beats 5-6 are discarded, and the following frame is good.
REQ-034 Two frames back to back with random s_valid gaps -> exactly two o_valid pulses and o_frames=2; assert rst_n low after beat 2 of a third frame -> outputs reach reset values and the next frame packs from class 0.
